// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice (generate/propagate).
module cla4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin,
    output logic [NIBBLE_W-1:0] Sum,
    output logic                Cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is expanded directly from Cin, so no ripple between bits.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign Sum  = p ^ c[NIBBLE_W-1:0];
    assign Cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds or subtracts two WIDTH-bit operands one nibble per clock through a
// single shared CLA slice, with valid/ready handshakes on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;
    logic                cout_q;
    logic                out_valid_q;
    logic [IDX_W-1:0]    idx;
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                accept;
    logic                last_nibble;

    assign accept      = (state == IDLE) && bus.in_valid;
    assign last_nibble = (idx == LAST_IDX);

    assign slice_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign slice_b = b_q[idx*NIBBLE_W +: NIBBLE_W];

    cla4_slice u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .Sum  (slice_sum),
        .Cout (slice_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last_nibble)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Operand registers are only loaded on accept, so inputs changing during
    // RUN/DONE cannot disturb the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            carry_q     <= 1'b0;
            idx         <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        idx     <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    // idx stops on the last nibble rather than wrapping.
                    if (last_nibble) begin
                        out_valid_q <= 1'b1;
                        cout_q      <= slice_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector and random back-to-back bench for nibble_serial_adder.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
    } exp_t;

    vec_t vecs [9];
    exp_t expq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [16:0] r;
        if (sub) r = {(a >= b), 16'(a - b)};
        else     r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        return r;
    endfunction

    // Starts an operation from IDLE and waits for out_valid; out_ready stays low.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          output logic [15:0] s, output logic c, output int lat);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.cin = ~cin; bus.sub = ~sub;
        check("in_ready_in_run", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        s = bus.sum;
        c = bus.cout;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s, s0;
        logic        c, c0;
        logic        acc, hs, seen_valid;
        logic [16:0] m;
        int          lat, cyc, last_acc, ops, results;
        exp_t        e;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
        vecs[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0};
        vecs[8] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_cout", 32'(bus.cout), 32'd0);

        // out_ready while idle must not do anything
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_out_ready_valid", 32'(bus.out_valid), 32'd0);
        check("idle_out_ready_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, c, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].exp_cout));
            release_out();
        end

        // Backpressure: results hold while new operands are offered
        run_op(16'h1234, 16'h0FF0, 1'b0, 1'b0, s0, c0, lat);
        check("bp_latency", 32'(lat), 32'd4);
        check("bp_sum_initial", 32'(s0), 32'h2224);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = (i != 1);
            bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1; bus.sub = 1'b0;
            bus.out_ready = 1'b0;
            tick();
            check($sformatf("bp%0d_sum", i), 32'(bus.sum), 32'h2224);
            check($sformatf("bp%0d_cout", i), 32'(bus.cout), 32'(c0));
            check($sformatf("bp%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_out();

        // Reset during RUN discards the operation
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrun_rst_sum", 32'(bus.sum), 32'd0);
        check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("midrun_rst_no_output", 32'(seen_valid), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, c, lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_sum", 32'(s), 32'h0002);
        check("post_rst_cout", 32'(c), 32'd0);
        release_out();

        // Back-to-back random operations with both handshakes held high
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        cyc = 0; last_acc = -1; ops = 0; results = 0;
        while (results < 1000 && cyc < 8000) begin
            acc = bus.in_valid && bus.in_ready;
            hs  = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (expq.size() == 0) begin
                    check("b2b_unexpected_result", 32'(bus.sum), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("b2b_result", {15'd0, bus.cout, bus.sum}, {15'd0, e.c, e.s});
                end
                results++;
            end
            if (acc) begin
                m = model(bus.a, bus.b, bus.cin, bus.sub);
                expq.push_back('{m[15:0], m[16]});
                if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                ops++;
            end
            tick();
            cyc++;
            if (acc) begin
                bus.a = 16'($urandom); bus.b = 16'($urandom);
                bus.cin = 1'($urandom); bus.sub = 1'($urandom);
                if (ops == 1000) bus.in_valid = 1'b0;
            end
        end
        check("b2b_result_count", 32'(results), 32'd1000);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 The block SHALL have derived constant NIBBLES = WIDTH/4, meaning the number of 4-bit slices per operation.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand pair and controls are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the unsigned operands.
REQ-008 The block SHALL have port cin, input, 1 bit: the carry-in, used only when sub=0.
REQ-009 The block SHALL have port sub, input, 1 bit: 1 selects a - b.
REQ-010 The block SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-013 The block SHALL have port cout, output, 1 bit: the final carry out of bit WIDTH-1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-016 An accept SHALL occur at a rising edge where in_valid=1 and in_ready=1, and SHALL do all of the following:
- latch a;
- latch b, or ~b when sub=1;
- set the carry register to cin, or to 1 when sub=1;
- clear the nibble index;
- clear sum;
- go to RUN.
REQ-017 At each edge in RUN, the block SHALL:
- add latched nibble[idx] of a and of b (or ~b) plus the carry register, through one 4-bit carry-lookahead slice;
- write the 4-bit result into sum[4*idx+3:4*idx];
- load the slice carry-out into the carry register;
- increment idx.
REQ-018 When idx = NIBBLES-1 is processed, the block SHALL go to DONE, set out_valid=1 and drive cout with that slice's carry-out.
REQ-019 Latency SHALL be exactly NIBBLES cycles: with an accept at edge k, out_valid SHALL first be 1 after edge k+NIBBLES.
REQ-020 In DONE, sum, cout and out_valid SHALL hold stable until an edge where out_ready=1; the block SHALL then clear out_valid and return to IDLE.
REQ-021 The earliest next accept SHALL be at the edge after the output handshake, giving a throughput of one operation per NIBBLES+2 cycles.
REQ-022 in_valid asserted outside IDLE SHALL be ignored, and a, b, cin and sub SHALL NOT affect an operation in flight.
REQ-023 out_ready asserted outside DONE SHALL have no effect.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; for sub=1, cout=1 SHALL mean no borrow (a >= b).
REQ-025 The nibble index SHALL be ceil(log2(NIBBLES)) bits wide and SHALL never wrap inside RUN.

Reset
REQ-026 While rst=1 at an edge, the block SHALL go to IDLE and set out_valid=0, sum=0, cout=0, carry register=0 and idx=0; in_ready SHALL be 1 after that edge.
REQ-027 rst SHALL take priority over all handshakes; a reset during RUN or DONE SHALL discard the operation with no output.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the constant NIBBLE_W=4.
REQ-029 The block SHALL instantiate exactly one sub-module, cla4_slice: a combinational 4-bit generate/propagate adder with inputs A[3:0], B[3:0] and Cin, and outputs Sum[3:0] and Cout.
REQ-030 All state SHALL be updated in a single clocked process, with no latches and no combinational path from in_valid to out_valid.

Verification (WIDTH=16)
REQ-031 Basic add: a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, out_valid exactly 4 cycles after accept.
REQ-032 Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0.
REQ-033 Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> sum and cout stay stable, in_ready=0, and no second operation starts.
REQ-035 Reset mid-RUN: assert rst after nibble 2 -> after the next edge, out_valid=0, sum=0, in_ready=1; a following add 0x0001+0x0001 -> 0x0002.
REQ-036 Back-to-back: in_valid and out_ready held at 1 -> accepts spaced exactly 6 cycles apart, and results match a reference model over 1000 random operations.
